// File: rtl/acc_seq_if.sv
// Sequencer-side bundle: sweep control/status plus the pmem read port and SFP strobes.
// With ACC_SEQ_HOLD_EN defined the bundle also carries the downstream 'hold' input.
interface acc_seq_if #(
  parameter int addr_bw = 11,
  parameter int idx_bw  = 4
);
  logic               start;
  logic               busy;
  logic               done;
  logic               CEN_pmem;
  logic               WEN_pmem;
  logic [addr_bw-1:0] A_pmem;
  logic               acc;
  logic               acc_clr;
  logic               pix_valid;
  logic [idx_bw-1:0]  pix_idx;
`ifdef ACC_SEQ_HOLD_EN
  logic               hold;

  modport master (
    input  start, hold,
    output busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, pix_valid, pix_idx
  );
  modport slave (
    output start, hold,
    input  busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, pix_valid, pix_idx
  );
`else
  modport master (
    input  start,
    output busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, pix_valid, pix_idx
  );
  modport slave (
    output start,
    input  busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, acc_clr, pix_valid, pix_idx
  );
`endif
endinterface

// File: rtl/acc_seq.sv
// Accumulation read sequencer: per output pixel, clear SFP, issue the nine kij pmem reads, strobe acc, emit.
// Optional ACC_SEQ_HOLD_EN adds a 'hold' input that stretches EMIT (downstream backpressure).
module acc_seq #(
  parameter int len_kij_sqrt  = 3,
  parameter int len_onij_sqrt = 4,
  parameter int kij_stride    = 37,
  parameter int addr_bw       = 11,
  parameter int idx_bw        = 4
) (
  input  logic     clk,
  input  logic     reset,
  acc_seq_if.master bus
);
  localparam int len_nij_sqrt = len_onij_sqrt + len_kij_sqrt - 1;
  localparam int len_kij      = len_kij_sqrt * len_kij_sqrt;
  localparam int len_onij     = len_onij_sqrt * len_onij_sqrt;
  localparam int kij_bw       = $clog2(len_kij);

  localparam logic [kij_bw-1:0] KIJ_LAST = kij_bw'(len_kij - 1);
  localparam logic [idx_bw-1:0] PIX_LAST = idx_bw'(len_onij - 1);

  typedef enum logic [2:0] {IDLE, CLR, READ, DRAIN, EMIT} state_t;

  state_t             state_q;
  logic [kij_bw-1:0]  kij_q;
  logic [idx_bw-1:0]  pix_q;
  logic               cen_q;
  logic [addr_bw-1:0] a_q;
  logic               acc_q;
  logic               clr_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               hold_w;

`ifdef ACC_SEQ_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  // Full-precision address, truncated only on return.
  function automatic logic [addr_bw-1:0] pmem_addr(input int pix, input int kij);
    int full;
    full = kij * kij_stride
         + (pix / len_onij_sqrt + kij / len_kij_sqrt) * len_nij_sqrt
         + (pix % len_onij_sqrt) + (kij % len_kij_sqrt);
    return addr_bw'(full);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      kij_q   <= '0;
      pix_q   <= '0;
      cen_q   <= 1'b1;
      a_q     <= '0;
      acc_q   <= 1'b0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // acc tracks the read issued one cycle earlier (1-cycle pmem latency).
      acc_q  <= ~cen_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= CLR;
            pix_q   <= '0;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CLR: begin
          clr_q   <= 1'b0;
          kij_q   <= '0;
          cen_q   <= 1'b0;
          a_q     <= pmem_addr(int'(pix_q), 0);
          state_q <= READ;
        end
        READ: begin
          if (kij_q == KIJ_LAST) begin
            cen_q   <= 1'b1;
            state_q <= DRAIN;
          end else begin
            kij_q <= kij_q + 1'b1;
            a_q   <= pmem_addr(int'(pix_q), int'(kij_q) + 1);
          end
        end
        DRAIN: begin
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: begin
          if (!hold_w) begin
            valid_q <= 1'b0;
            if (pix_q == PIX_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pix_q   <= pix_q + 1'b1;
              clr_q   <= 1'b1;
              state_q <= CLR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.CEN_pmem  = cen_q;
  assign bus.WEN_pmem  = 1'b1;
  assign bus.A_pmem    = a_q;
  assign bus.acc       = acc_q;
  assign bus.acc_clr   = clr_q;
  assign bus.pix_valid = valid_q;
  assign bus.pix_idx   = pix_q;
endmodule

// File: tb/tb_acc_seq.sv
// Scoreboard bench for acc_seq: random pmem contents, pmem/SFP behavioural models, expected reads,
// pixels and done pulses queued at each start and popped by an independent negedge monitor.
module tb_acc_seq;
  localparam int ADDR_BW = 11;
  localparam int IDX_BW  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acc_seq_if #(.addr_bw(ADDR_BW), .idx_bw(IDX_BW)) bus();

  acc_seq #(
    .len_kij_sqrt(3), .len_onij_sqrt(4), .kij_stride(37), .addr_bw(ADDR_BW), .idx_bw(IDX_BW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pmem with 1-cycle read latency and an SFP accumulator driven by the DUT strobes
  logic [7:0] mem [0:2047];
  logic [7:0] rdata;
  int         sfp;
  always @(posedge clk) begin
    if (!bus.CEN_pmem) rdata <= mem[bus.A_pmem];
    if (bus.acc_clr) sfp <= 0;
    else if (bus.acc) sfp <= sfp + int'(rdata);
  end

  typedef struct { int idx; int cyc; int sum; } pix_t;
  typedef struct { int addr; int cyc; } rd_t;
  pix_t pix_q[$];
  rd_t  rd_q[$];
  int   done_q[$];
  int   acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected (cyc %0d)", name, cyc);
  endtask

  function automatic int ref_addr(input int p, input int k);
    int orow, ocol, kr, kc;
    orow = p / 4; ocol = p % 4; kr = k / 3; kc = k % 3;
    return k * 37 + (orow + kr) * 6 + (ocol + kc);
  endfunction

  // Queue everything a sweep sampled at t0 should produce up to relative cycle last_c.
  task automatic push_sweep(input int t0, input int last_c);
    for (int p = 0; p < 16; p++) begin
      int sum = 0;
      for (int k = 0; k < 9; k++) begin
        rd_t r;
        r.addr = ref_addr(p, k);
        r.cyc  = t0 + (12 * p + 2 + k) - 1;
        sum += int'(mem[r.addr]);
        if (12 * p + 2 + k <= last_c) rd_q.push_back(r);
      end
      if (12 * p + 12 <= last_c) begin
        pix_t e;
        e.idx = p; e.cyc = t0 + 12 * p + 11; e.sum = sum;
        pix_q.push_back(e);
      end
    end
    if (193 <= last_c) done_q.push_back(t0 + 192);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.acc_clr) acc_cnt = 0;
      if (bus.acc) acc_cnt++;
      if (!bus.CEN_pmem) begin
        if (rd_q.size() == 0) fail_evt("unexpected_read");
        else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_addr", 64'(bus.A_pmem), 64'(r.addr));
          check("rd_cycle", 64'(cyc), 64'(r.cyc));
          check("rd_wen", 64'(bus.WEN_pmem), 64'(1));
        end
      end
      if (bus.pix_valid) begin
        if (pix_q.size() == 0) fail_evt("unexpected_pix_valid");
        else begin
          pix_t e;
          e = pix_q.pop_front();
          $display("pixel %0d at cyc %0d: sfp=%0d exp=%0d acc_strobes=%0d", bus.pix_idx, cyc, sfp, e.sum, acc_cnt);
          check("pix_idx", 64'(bus.pix_idx), 64'(e.idx));
          check("pix_cycle", 64'(cyc), 64'(e.cyc));
          check("pix_sum", 64'(sfp), 64'(e.sum));
          check("pix_acc_count", 64'(acc_cnt), 64'(9));
          check("pix_busy", 64'(bus.busy), 64'(1));
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) fail_evt("unexpected_done");
        else begin
          int d;
          d = done_q.pop_front();
          $display("done at cyc %0d (expected %0d)", cyc, d);
          check("done_cycle", 64'(cyc), 64'(d));
          check("done_busy", 64'(bus.busy), 64'(0));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(bus.busy),      64'(0));
    check({tag, "_done"},      64'(bus.done),      64'(0));
    check({tag, "_cen"},       64'(bus.CEN_pmem),  64'(1));
    check({tag, "_wen"},       64'(bus.WEN_pmem),  64'(1));
    check({tag, "_addr"},      64'(bus.A_pmem),    64'(0));
    check({tag, "_acc"},       64'(bus.acc),       64'(0));
    check({tag, "_acc_clr"},   64'(bus.acc_clr),   64'(0));
    check({tag, "_pix_valid"}, 64'(bus.pix_valid), 64'(0));
    check({tag, "_pix_idx"},   64'(bus.pix_idx),   64'(0));
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Pulse start for one sampling edge; returns cyc as seen during cycle 1.
  task automatic start_sweep(output int t0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && pix_q.size() == 0 && done_q.size() == 0) break;
    end
    if (rd_q.size() != 0 || pix_q.size() != 0 || done_q.size() != 0) begin
      fail_evt({tag, "_timeout"});
      rd_q.delete(); pix_q.delete(); done_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    bus.start = 1'b0;
`ifdef ACC_SEQ_HOLD_EN
    bus.hold = 1'b0;
`endif
    fill_mem();
    #12;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // single sweep
    fill_mem();
    start_sweep(t0);
    push_sweep(t0, 1000);
    wait_drain(260, "sweep1");

    // start held high: exactly two back-to-back sweeps
    fill_mem();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    push_sweep(t0, 1000);
    push_sweep(t0 + 193, 1000);
    for (int i = 0; i < 300; i++) begin
      if (cyc >= t0 + 198) break;
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_drain(450, "backtoback");

    // async reset during READ of pixel 4 (cycle 50)
    fill_mem();
    start_sweep(t0);
    push_sweep(t0, 49);
    for (int i = 0; i < 200; i++) begin
      if (cyc == t0 + 48) break;
      @(negedge clk);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    check("midrst_reads_left", 64'(rd_q.size()), 64'(0));
    check("midrst_pix_left", 64'(pix_q.size()), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_hold_acc", 64'(bus.acc), 64'(0));
      check("rst_hold_pix_valid", 64'(bus.pix_valid), 64'(0));
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle_busy", 64'(bus.busy), 64'(0));
      check("post_rst_idle_acc", 64'(bus.acc), 64'(0));
    end
    start_sweep(t0);
    push_sweep(t0, 1000);
    wait_drain(260, "restart");

    // random idle gaps between further sweeps
    for (int s = 0; s < 2; s++) begin
      fill_mem();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      start_sweep(t0);
      push_sweep(t0, 1000);
      wait_drain(260, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
